// File: rtl/hcms_pkg.sv
// hcms_pkg: shared state type, control-word constants and byte-index helper
// for the HCMS-29xx frame sequencer.
package hcms_pkg;

   typedef enum logic [2:0] {RST_HOLD, CW1, CW0, IDLE, FRAME} state_t;

   localparam logic [7:0] CW1_VALUE       = 8'h81;
   localparam int         CW0_SLEEP_BIT   = 6;
   localparam int         CW0_PEAK_LSB    = 4;
   localparam int         CW0_BRIGHT_LSB  = 0;
   localparam logic [6:0] GLYPH_FIRST     = 7'h20;
   localparam logic [6:0] GLYPH_LAST      = 7'h5F;
   localparam int         BYTES_PER_FRAME = 20;

   function automatic logic [7:0] cw0_byte(input logic blank, input logic [1:0] peak,
                                           input logic [3:0] bright);
      cw0_byte = 8'h00;
      cw0_byte[CW0_SLEEP_BIT] = ~blank;
      cw0_byte[CW0_PEAK_LSB +: 2] = peak;
      cw0_byte[CW0_BRIGHT_LSB +: 4] = bright;
   endfunction

   // Splits a frame byte index 0..19 into {character[1:0], column[2:0]}.
   function automatic logic [4:0] idx_pos(input logic [4:0] idx);
      logic [1:0] c;
      c = idx >= 5'd15 ? 2'd3 : idx >= 5'd10 ? 2'd2 : idx >= 5'd5 ? 2'd1 : 2'd0;
      idx_pos = {c, 3'(idx - 5'(c) * 5'd5)};
   endfunction

endpackage

// File: rtl/hcms_font_rom.sv
// hcms_font_rom: 5x7 font for codes 0x20..0x5F, addressed {glyph, column},
// bit0 = top row; output register only loads while en_i is high.
module hcms_font_rom (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       en_i,
   input  logic [8:0] addr_i,
   output logic [7:0] data_o
);

   logic [39:0] glyph;
   logic [7:0]  data_d, data_q;

   always_comb begin
      case (addr_i[8:3])
         6'd0:  glyph = 40'h0000000000;
         6'd1:  glyph = 40'h00005F0000;
         6'd2:  glyph = 40'h0007000700;
         6'd3:  glyph = 40'h147F147F14;
         6'd4:  glyph = 40'h242A7F2A12;
         6'd5:  glyph = 40'h2313086462;
         6'd6:  glyph = 40'h3649552250;
         6'd7:  glyph = 40'h0005030000;
         6'd8:  glyph = 40'h001C224100;
         6'd9:  glyph = 40'h0041221C00;
         6'd10: glyph = 40'h082A1C2A08;
         6'd11: glyph = 40'h08083E0808;
         6'd12: glyph = 40'h0050300000;
         6'd13: glyph = 40'h0808080808;
         6'd14: glyph = 40'h0060600000;
         6'd15: glyph = 40'h2010080402;
         6'd16: glyph = 40'h3E5149453E;
         6'd17: glyph = 40'h00427F4000;
         6'd18: glyph = 40'h4261514946;
         6'd19: glyph = 40'h2141454B31;
         6'd20: glyph = 40'h1814127F10;
         6'd21: glyph = 40'h2745454539;
         6'd22: glyph = 40'h3C4A494930;
         6'd23: glyph = 40'h0171090503;
         6'd24: glyph = 40'h3649494936;
         6'd25: glyph = 40'h064949291E;
         6'd26: glyph = 40'h0036360000;
         6'd27: glyph = 40'h0056360000;
         6'd28: glyph = 40'h0008142241;
         6'd29: glyph = 40'h1414141414;
         6'd30: glyph = 40'h4122140800;
         6'd31: glyph = 40'h0201510906;
         6'd32: glyph = 40'h324979413E;
         6'd33: glyph = 40'h7E1111117E;
         6'd34: glyph = 40'h7F49494936;
         6'd35: glyph = 40'h3E41414122;
         6'd36: glyph = 40'h7F4141221C;
         6'd37: glyph = 40'h7F49494941;
         6'd38: glyph = 40'h7F09090101;
         6'd39: glyph = 40'h3E41415132;
         6'd40: glyph = 40'h7F0808087F;
         6'd41: glyph = 40'h00417F4100;
         6'd42: glyph = 40'h2040413F01;
         6'd43: glyph = 40'h7F08142241;
         6'd44: glyph = 40'h7F40404040;
         6'd45: glyph = 40'h7F0204027F;
         6'd46: glyph = 40'h7F0408107F;
         6'd47: glyph = 40'h3E4141413E;
         6'd48: glyph = 40'h7F09090906;
         6'd49: glyph = 40'h3E4151215E;
         6'd50: glyph = 40'h7F09192946;
         6'd51: glyph = 40'h4649494931;
         6'd52: glyph = 40'h01017F0101;
         6'd53: glyph = 40'h3F4040403F;
         6'd54: glyph = 40'h1F2040201F;
         6'd55: glyph = 40'h7F2018207F;
         6'd56: glyph = 40'h6314081463;
         6'd57: glyph = 40'h0304780403;
         6'd58: glyph = 40'h6151494543;
         6'd59: glyph = 40'h00007F4141;
         6'd60: glyph = 40'h0204081020;
         6'd61: glyph = 40'h41417F0000;
         6'd62: glyph = 40'h0402010204;
         6'd63: glyph = 40'h4040404040;
         default: glyph = 40'h0000000000;
      endcase
      data_d = addr_i[2:0] == 3'd0 ? glyph[39:32] :
               addr_i[2:0] == 3'd1 ? glyph[31:24] :
               addr_i[2:0] == 3'd2 ? glyph[23:16] :
               addr_i[2:0] == 3'd3 ? glyph[15:8]  : glyph[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) data_q <= 8'h00;
      else if (en_i) data_q <= data_d;
   end

   assign data_o = data_q;

endmodule

// File: rtl/hcms_frame_ctrl.sv
// hcms_frame_ctrl: 4-character buffer, font lookup and reset/control-word/dot-frame
// byte sequencing toward the hcms_serial byte shifter.
module hcms_frame_ctrl
   import hcms_pkg::*;
#(
   parameter int         RESET_CYCLES   = 16,
   parameter int         REFRESH_CYCLES = 0,
   parameter logic [1:0] PEAK_CURRENT   = 2'b00
) (
   input  logic       i_CLK,
   input  logic       i_RST_N,
   input  logic       i_char_we,
   input  logic [1:0] i_char_addr,
   input  logic [6:0] i_char_data,
   input  logic [3:0] i_brightness,
   input  logic       i_bright_upd,
   input  logic       i_blank,
   output logic [7:0] o_tx_data,
   output logic       o_tx_cmd,
   output logic       o_tx_last,
   output logic       o_tx_valid,
   input  logic       i_tx_ready,
   output logic       o_disp_reset_n,
   output logic       o_busy,
   output logic       o_frame_done
);

   state_t      state_q, state_d;
   logic [31:0] hold_q, hold_d, refresh_q, refresh_d;
   logic [6:0]  chars_q [4];
   logic        dirty_q, tick_q, pend_q, ok_q;
   logic [3:0]  bright_q;
   logic [4:0]  idx_q, idx_d;
   logic        present_q, present_d;
   logic        valid_q, valid_d, cmd_q, cmd_d, last_q, last_d, done_q, done_d;
   logic [7:0]  data_q, data_d, rom_data;
   logic        accept, wrap, enter_frame, build_cw0, fetch;
   logic [4:0]  pos;
   logic [6:0]  code;

   assign accept    = valid_q & i_tx_ready;
   assign wrap      = (REFRESH_CYCLES != 0) && (refresh_q == 32'(REFRESH_CYCLES - 1));
   assign refresh_d = (wrap || REFRESH_CYCLES == 0) ? 32'd0 : refresh_q + 32'd1;
   assign fetch     = (state_q == FRAME) && !present_q;
   assign pos       = idx_pos(idx_q);
   assign code      = chars_q[pos[4:3]];

   // ROM only reloads in the fetch cycle so a buffer write cannot disturb a presented byte.
   hcms_font_rom u_rom (
      .clk_i   (i_CLK),
      .rst_n_i (i_RST_N),
      .en_i    (fetch),
      .addr_i  ({6'(code - GLYPH_FIRST), pos[2:0]}),
      .data_o  (rom_data)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      idx_d       = idx_q;
      present_d   = present_q;
      valid_d     = valid_q;
      data_d      = data_q;
      cmd_d       = cmd_q;
      last_d      = last_q;
      done_d      = 1'b0;
      enter_frame = 1'b0;
      build_cw0   = 1'b0;
      case (state_q)
         RST_HOLD: begin
            hold_d = hold_q + 32'd1;
            if (hold_q + 32'd1 >= 32'(RESET_CYCLES)) begin
               state_d = CW1;
               valid_d = 1'b1;
               data_d  = CW1_VALUE;
               cmd_d   = 1'b1;
               last_d  = 1'b1;
            end
         end
         CW1: build_cw0 = accept;
         CW0: if (accept) begin
            valid_d     = 1'b0;
            state_d     = IDLE;
            enter_frame = dirty_q;
         end
         IDLE: begin
            build_cw0   = pend_q;
            enter_frame = !pend_q && (dirty_q || tick_q);
         end
         FRAME: if (!present_q) begin
            present_d = 1'b1;
            valid_d   = 1'b1;
            cmd_d     = 1'b0;
            last_d    = idx_q == 5'(BYTES_PER_FRAME - 1);
         end else if (accept) begin
            present_d = 1'b0;
            valid_d   = 1'b0;
            done_d    = last_q;
            idx_d     = last_q ? 5'd0 : idx_q + 5'd1;
            state_d   = last_q ? IDLE : FRAME;
         end
         default: state_d = RST_HOLD;
      endcase
      if (build_cw0) begin
         state_d = CW0;
         valid_d = 1'b1;
         data_d  = cw0_byte(i_blank, PEAK_CURRENT, bright_q);
         cmd_d   = 1'b1;
         last_d  = 1'b1;
      end
      if (enter_frame) begin
         state_d   = FRAME;
         valid_d   = 1'b0;
         present_d = 1'b0;
         idx_d     = 5'd0;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q   <= RST_HOLD;
         hold_q    <= 32'd0;
         refresh_q <= 32'd0;
         for (int i = 0; i < 4; i++) chars_q[i] <= 7'h20;
         dirty_q   <= 1'b0;
         tick_q    <= 1'b0;
         pend_q    <= 1'b0;
         ok_q      <= 1'b0;
         bright_q  <= 4'hF;
         idx_q     <= 5'd0;
         present_q <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= 8'h00;
         cmd_q     <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         refresh_q <= refresh_d;
         if (i_char_we) chars_q[i_char_addr] <= i_char_data;
         dirty_q   <= i_char_we | (dirty_q & ~enter_frame);
         tick_q    <= wrap | (tick_q & ~enter_frame);
         pend_q    <= i_bright_upd | (pend_q & ~build_cw0);
         if (i_bright_upd) bright_q <= i_brightness;
         if (fetch) ok_q <= (code >= GLYPH_FIRST) && (code <= GLYPH_LAST);
         idx_q     <= idx_d;
         present_q <= present_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         cmd_q     <= cmd_d;
         last_q    <= last_d;
         done_q    <= done_d;
      end
   end

   assign o_tx_data      = state_q == FRAME ? (ok_q ? rom_data : 8'h00) : data_q;
   assign o_tx_cmd       = cmd_q;
   assign o_tx_last      = last_q;
   assign o_tx_valid     = valid_q;
   assign o_disp_reset_n = state_q != RST_HOLD;
   assign o_busy         = state_q != IDLE;
   assign o_frame_done   = done_q;

endmodule

// File: tb/tb_hcms_frame_ctrl.sv
// tb_hcms_frame_ctrl: transaction-level model of the byte stream (pixel-row glyphs,
// control-word arithmetic) checked against every accepted byte, plus literal pins.
module tb_hcms_frame_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       i_char_we = 1'b0, i_bright_upd = 1'b0, i_blank = 1'b0, i_tx_ready = 1'b1;
   logic [1:0] i_char_addr = 2'd0;
   logic [6:0] i_char_data = 7'd0;
   logic [3:0] i_brightness = 4'hF;
   logic [7:0] o_tx_data;
   logic       o_tx_cmd, o_tx_last, o_tx_valid, o_disp_reset_n, o_busy, o_frame_done;

   int         total = 0, bad = 0, ready_mode = 0, in_frame = 0, done_cnt = 0, d0;
   logic [9:0] exp_q[$], log_q[$], prev_word;
   logic       done_exp = 1'b0, have_prev = 1'b0;
   logic [6:0] mbuf [4] = '{7'h20, 7'h20, 7'h20, 7'h20};
   logic [3:0] mbright = 4'hF;
   logic       mblank = 1'b0;
   logic [7:0] abcd [20] = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E, 8'h7F, 8'h49, 8'h49, 8'h49, 8'h36,
                             8'h3E, 8'h41, 8'h41, 8'h41, 8'h22, 8'h7F, 8'h41, 8'h41, 8'h22, 8'h1C};

   hcms_frame_ctrl dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_char_we(i_char_we), .i_char_addr(i_char_addr),
      .i_char_data(i_char_data), .i_brightness(i_brightness), .i_bright_upd(i_bright_upd),
      .i_blank(i_blank), .o_tx_data(o_tx_data), .o_tx_cmd(o_tx_cmd), .o_tx_last(o_tx_last),
      .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_disp_reset_n(o_disp_reset_n),
      .o_busy(o_busy), .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endfunction

   // Glyphs as 7 pixel rows (top first), each row 5 pixels left to right.
   function automatic logic [34:0] rows(input logic [6:0] c);
      case (c)
         7'h41:   rows = 35'b01110_10001_10001_10001_11111_10001_10001;
         7'h42:   rows = 35'b11110_10001_10001_11110_10001_10001_11110;
         7'h43:   rows = 35'b01110_10001_10000_10000_10000_10001_01110;
         7'h44:   rows = 35'b11100_10010_10001_10001_10001_10010_11100;
         default: rows = '0;
      endcase
   endfunction

   function automatic logic [7:0] col_byte(input logic [6:0] c, input int col);
      logic [34:0] r = rows(c);
      col_byte = 8'h00;
      for (int k = 0; k < 7; k++) col_byte[k] = r[34 - 5 * k - col];
   endfunction

   function automatic void push_frame();
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, i == 19, col_byte(mbuf[i / 5], i % 5)});
   endfunction

   function automatic void push_cw0();
      exp_q.push_back({2'b11, 8'((mblank ? 0 : 64) + int'(mbright))});
   endfunction

   initial forever begin
      @(posedge clk);
      #1 i_tx_ready = ready_mode == 2 ? 1'b0 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         have_prev = 1'b0;
         done_exp  = 1'b0;
         in_frame  = 0;
      end else begin
         check("frame_done", o_frame_done, done_exp);
         if (o_frame_done) done_cnt++;
         done_exp = 1'b0;
         if (have_prev) begin
            check("valid_held", o_tx_valid, 1);
            check("word_held", {o_tx_cmd, o_tx_last, o_tx_data}, prev_word);
         end
         have_prev = o_tx_valid && !i_tx_ready;
         prev_word = {o_tx_cmd, o_tx_last, o_tx_data};
         if (o_tx_valid && i_tx_ready) begin
            log_q.push_back(prev_word);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte got=%0h want=none", prev_word);
            end else check("byte", prev_word, exp_q.pop_front());
            if (!o_tx_cmd) begin
               in_frame++;
               if (o_tx_last) begin
                  done_exp = 1'b1;
                  in_frame = 0;
               end
            end
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [6:0] d);
      i_char_we = 1'b1; i_char_addr = a; i_char_data = d; mbuf[a] = d;
      @(posedge clk); #2 i_char_we = 1'b0;
   endtask

   task automatic upd(input logic [3:0] b);
      i_brightness = b; i_bright_upd = 1'b1; mbright = b;
      @(posedge clk); #2 i_bright_upd = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_byte(input int idx);
      int n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!(in_frame == idx && o_tx_valid) && n < 300);
      check("wait_byte_timeout", n < 300, 1);
   endtask

   task automatic release_and_count();
      int n = 0;
      @(negedge clk); #1 rst_n = 1'b1;
      while (!o_disp_reset_n && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("reset_hold_cycles", n, 16);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", o_tx_valid, 0);
      check("rst_data", o_tx_data, 0);
      check("rst_cmd", o_tx_cmd, 0);
      check("rst_last", o_tx_last, 0);
      check("rst_busy", o_busy, 1);
      check("rst_done", o_frame_done, 0);
      check("rst_disp", o_disp_reset_n, 0);

      exp_q.push_back(10'h381);
      push_cw0();
      release_and_count();
      drain(100);
      check("idle_busy", o_busy, 0);
      check("init_log_n", log_q.size(), 2);
      check("init_cw1", log_q[0], 10'h381);
      check("init_cw0", log_q[1], 10'h34F);

      log_q.delete();
      d0 = done_cnt;
      ready_mode = 2;
      @(posedge clk); #2;
      upd(4'hF);
      push_cw0();
      wr(0, 7'h41); wr(1, 7'h42); wr(2, 7'h43); wr(3, 7'h44);
      push_frame();
      for (int i = 0; i < 20; i++) check("model_font", col_byte(mbuf[i / 5], i % 5), abcd[i]);
      repeat (3) @(posedge clk);
      ready_mode = 0;
      drain(200);
      check("abcd_log_n", log_q.size(), 21);
      check("abcd_cw0", log_q[0], 10'h34F);
      for (int i = 0; i < 20; i++) check("abcd_lit", log_q[i + 1], {1'b0, i == 19, abcd[i]});
      check("abcd_done_cnt", done_cnt - d0, 1);

      log_q.delete();
      d0 = done_cnt;
      ready_mode = 1;
      wr(0, 7'h41);
      push_frame();
      drain(600);
      ready_mode = 0;
      check("bp_log_n", log_q.size(), 20);
      check("bp_done_cnt", done_cnt - d0, 1);

      log_q.delete();
      d0 = done_cnt;
      wr(3, 7'h44);
      push_frame();
      wait_byte(7);
      i_brightness = 4'h3; i_bright_upd = 1'b1; mbright = 4'h3;
      i_char_we = 1'b1; i_char_addr = 2'd0; i_char_data = 7'h43; mbuf[0] = 7'h43;
      push_cw0();
      push_frame();
      @(posedge clk); #2 i_char_we = 1'b0; i_bright_upd = 1'b0;
      drain(300);
      check("mid_log_n", log_q.size(), 41);
      check("mid_cw0", log_q[20], 10'h343);
      check("mid_second_first", log_q[21], 10'h03E);
      check("mid_done_cnt", done_cnt - d0, 2);

      log_q.delete();
      wr(0, 7'h7E);
      push_frame();
      drain(200);
      for (int i = 0; i < 5; i++) check("bad_code_col", log_q[i], 10'h000);
      i_blank = 1'b1; mblank = 1'b1;
      upd(4'hF);
      push_cw0();
      drain(100);
      check("blank_cw0", log_q[log_q.size() - 1], 10'h30F);
      i_blank = 1'b0; mblank = 1'b0;

      wr(1, 7'h42);
      push_frame();
      wait_byte(12);
      rst_n = 1'b0;
      #1;
      check("arst_valid", o_tx_valid, 0);
      check("arst_disp", o_disp_reset_n, 0);
      check("arst_busy", o_busy, 1);
      exp_q.delete();
      mbuf = '{7'h20, 7'h20, 7'h20, 7'h20};
      mbright = 4'hF;
      repeat (2) @(negedge clk);
      log_q.delete();
      exp_q.push_back(10'h381);
      push_cw0();
      release_and_count();
      drain(100);
      check("restart_cw1", log_q[0], 10'h381);
      check("restart_cw0", log_q[1], 10'h34F);
      check("restart_no_frame", log_q.size(), 2);
      log_q.delete();
      wr(0, 7'h41);
      push_frame();
      drain(200);
      check("restart_a0", log_q[0], 10'h07E);
      check("restart_space", log_q[5], 10'h000);
      check("restart_busy", o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hcms_frame_ctrl.md
# hcms_frame_ctrl

Frame sequencer for a 4-character HCMS-29xx dot-matrix display. Holds a 4-entry character buffer written by the host and converts each character to 5 column bytes through a font ROM. Sequences display reset, both control words and full 160-bit dot-register frames into the downstream byte serializer over a valid/ready handshake. Sits between user logic and the existing `hcms_serial` byte shifter.

## Interface
- `RESET_CYCLES`, 16: cycles `o_disp_reset_n` is held low after reset.
- `REFRESH_CYCLES`, 0: period of the forced frame resend in cycles; 0 disables it.
- `PEAK_CURRENT`, 2'b00: peak-current field of control word 0.
- `i_CLK`  in  1: single clock, all logic on the rising edge.
- `i_RST_N`  in  1: reset, asynchronous, active-low.
- `i_char_we`  in  1: write strobe for the character buffer.
- `i_char_addr`  in  2: character position; 0 is leftmost.
- `i_char_data`  in  7: ASCII code.
- `i_brightness`  in  4: brightness, sampled on `i_bright_upd`.
- `i_bright_upd`  in  1: pulse; requests a control word 0 resend.
- `i_blank`  in  1: level; when 1, control word 0 carries sleep (bit6=0).
- `o_tx_data`  out  8: byte to the serializer.
- `o_tx_cmd`  out  1: 1 = control register, 0 = dot register.
- `o_tx_last`  out  1: 1 = serializer ends the chip-enable window after this byte.
- `o_tx_valid`  out  1: byte valid.
- `i_tx_ready`  in  1: serializer accepts when `o_tx_valid & i_tx_ready`.
- `o_disp_reset_n`  out  1: display reset, active-low.
- `o_busy`  out  1: 1 in every state except IDLE.
- `o_frame_done`  out  1: one-cycle pulse after the last dot byte is accepted.

## Operation
- Buffer reset value is 0x20 (space) in all 4 entries. Writes are accepted in any state.
- Dirty flag:
  - Set by any write.
  - Cleared on entry to FRAME.
  - If a write coincides with the clear, the set wins.
- Brightness register: reset value 4'hF. It loads on `i_bright_upd`, which also sets `bright_pend`.
- States:
  - RST_HOLD: `o_disp_reset_n`=0 for RESET_CYCLES cycles, then go to CW1.
  - CW1: send 8'h81, cmd=1, last=1, then go to CW0.
  - CW0: send {1'b0, ~i_blank, PEAK_CURRENT, brightness}, cmd=1, last=1; clear `bright_pend`. Go to FRAME if dirty, else IDLE.
  - IDLE: in priority order:
    - `bright_pend` goes to CW0.
    - Dirty or refresh tick goes to FRAME.
    - Otherwise stay.
  - FRAME: 20 bytes in order char0 col0..col4, char1 col0..col4, and so on. cmd=0; last=1 only on byte 19. After byte 19 is accepted: pulse `o_frame_done` and go to IDLE.
- Pending requests raised during FRAME are serviced only after the frame completes. A frame is never split.
- Refresh counter:
  - Free-runs from 0 to REFRESH_CYCLES-1.
  - Wrap sets a sticky tick, cleared on FRAME entry.
- Font:
  - Codes 0x20–0x5F map to glyph (code−0x20), 5 bytes each; bit0 is the top row and bit7 is always 0.
  - All other codes produce 5 bytes of 0x00.
- `i_blank` is sampled only when a CW0 byte is built. A change in `i_blank` alone does not trigger a resend; the host pulses `i_bright_upd`.

## Timing
- Reset values:
  - `o_disp_reset_n`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_tx_cmd`=0, `o_tx_last`=0.
  - `o_busy`=1, `o_frame_done`=0, state RST_HOLD.
- Reset assertion mid-operation drops `o_tx_valid` immediately (asynchronous). The full sequence restarts from RST_HOLD.
- Handshake:
  - Once `o_tx_valid`=1, `o_tx_data`, `o_tx_cmd` and `o_tx_last` are held stable until accepted.
  - Valid never deasserts without acceptance, except on reset.
- Font ROM has 1-cycle registered latency. Each FRAME byte takes a FETCH cycle, then a PRESENT phase (valid high until accepted).
  - With `i_tx_ready` tied high: 2 cycles per byte, 40 cycles per frame.
  - `o_frame_done` is asserted the cycle after the byte-19 handshake.
- Control bytes need no fetch. Valid is asserted in the first cycle of CW1/CW0.
- Byte index: 5-bit counter, 0..19, wrapping to 0 on FRAME exit.

## Structure
- Package `hcms_pkg` holds:
  - the state enum;
  - `CW1_VALUE`=8'h81;
  - CW0 bit positions;
  - `GLYPH_FIRST`=7'h20 and `GLYPH_LAST`=7'h5F;
  - `BYTES_PER_FRAME`=20.
- Sub-module `hcms_font_rom`: 64×5 byte registered ROM, with address {glyph, column}.

## Test plan
- Reset, REFRESH_CYCLES=0, ready high:
  - `o_disp_reset_n` is low for 16 cycles.
  - Then 0x81 (cmd=1, last=1), then 0x4F (cmd=1, last=1).
  - Then no frame (buffer not dirty), `o_busy`=0.
- Write 0x41, 0x42, 0x43, 0x44 to addresses 0–3:
  - Bytes are 7E 11 11 11 7E 7F 49 49 49 36 3E 41 41 41 22 7F 41 41 22 1C, all cmd=0.
  - last=1 only on byte 19.
  - `o_frame_done` pulses once.
- Random `i_tx_ready` backpressure on the same frame: data, cmd and last stay stable while valid and unaccepted; the byte sequence is identical.
- `i_bright_upd` with brightness 4'h3 plus a write during byte 7 of a frame:
  - The frame completes all 20 bytes.
  - Then 0x43 is sent.
  - Then a second full frame follows.
- Write code 0x7E to address 0: the first 5 frame bytes are 0x00. `i_blank`=1 then `i_bright_upd`: CW0 byte 0x0F.
- Assert `i_RST_N` low at byte 12: valid drops in the same cycle. After release, the sequence restarts from RST_HOLD, and the buffer returns to spaces.
